// File: rtl/arith_seq_pkg.sv
// Shared types, select encodings and flag helper for the arithmetic-unit sequencer.
package arith_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_B    = 2'b00;
    localparam logic [1:0] SEL_NOTB = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;
    localparam logic [1:0] SEL_ONES = 2'b11;

    typedef struct packed {
        logic zero;
        logic ovf;
    } flags_t;

    // Overflow only occurs when both addends share a sign and the sum's sign differs from it.
    function automatic flags_t calcFlags(input logic aMsb, input logic yMsb,
                                         input logic dMsb, input logic dIsZero);
        flags_t result;
        result.zero = dIsZero;
        result.ovf  = (aMsb == yMsb) && (dMsb != aMsb);
        return result;
    endfunction

endpackage

// File: rtl/arith_op_sequencer_if.sv
// Request/response channel between a requester and the arithmetic-unit sequencer.
interface arith_op_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_s;
    logic             req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_d;
    logic             rsp_cout;
    logic             rsp_zero;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_s, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_d, rsp_cout, rsp_zero, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, req_s, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_d, rsp_cout, rsp_zero, rsp_ovf
    );
endinterface

// File: rtl/arith_op_sequencer_b_select.sv
// Reproduces the unit's B-operand mux so the sequencer knows the effective addend.
module arith_b_select
    import arith_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_s,
    output logic [WIDTH-1:0] o_y
);

    // Select B, its complement, zero or all-ones exactly as the gate-level mux does.
    always_comb begin
        o_y = i_b;
        case (i_s)
            SEL_B:    o_y = i_b;
            SEL_NOTB: o_y = ~i_b;
            SEL_ZERO: o_y = '0;
            SEL_ONES: o_y = '1;
            default:  o_y = i_b;
        endcase
    end

endmodule

// File: rtl/arith_op_sequencer.sv
// Clocked initiator for the 4-bit gate-level arithmetic unit: registers operands,
// waits out the gate propagation delay, then captures the sum with status flags.
module arith_op_sequencer
    import arith_seq_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    arith_op_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_s,
    output logic                 alu_cin,
    input  logic [WIDTH-1:0]     alu_d,
    input  logic                 alu_cout
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam int MSB = WIDTH - 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic [1:0]       r_aluS;
    logic             r_aluCin;
    logic             r_rspValid;
    logic [WIDTH-1:0] r_rspD;
    logic             r_rspCout;
    logic             r_rspZero;
    logic             r_rspOvf;

    logic [WIDTH-1:0] w_y;
    logic             w_reqReady;
    flags_t           w_flags;

    // Effective addend is derived from the registered operands, never the live request.
    arith_b_select #(.WIDTH(WIDTH)) u_bSelect (
        .i_b (r_aluB),
        .i_s (r_aluS),
        .o_y (w_y)
    );

    // Ready is withheld while reset is asserted so nothing is accepted during reset.
    assign w_reqReady = (r_state == IDLE) && !rst;
    assign w_flags    = calcFlags(r_aluA[MSB], w_y[MSB], alu_d[MSB], (alu_d == '0));

    // Three-phase sequence: accept and drive operands, count out the settle time, hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluS     <= '0;
            r_aluCin   <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspD     <= '0;
            r_rspCout  <= 1'b0;
            r_rspZero  <= 1'b0;
            r_rspOvf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_aluA   <= bus.req_a;
                        r_aluB   <= bus.req_b;
                        r_aluS   <= bus.req_s;
                        r_aluCin <= bus.req_cin;
                        r_count  <= CNT_LOAD;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_count != '0) begin
                        r_count <= r_count - CNT_W'(1);
                    end else begin
                        r_rspD     <= alu_d;
                        r_rspCout  <= alu_cout;
                        r_rspZero  <= w_flags.zero;
                        r_rspOvf   <= w_flags.ovf;
                        r_rspValid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_a         = r_aluA;
    assign alu_b         = r_aluB;
    assign alu_s         = r_aluS;
    assign alu_cin       = r_aluCin;
    assign bus.req_ready = w_reqReady;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_d     = r_rspD;
    assign bus.rsp_cout  = r_rspCout;
    assign bus.rsp_zero  = r_rspZero;
    assign bus.rsp_ovf   = r_rspOvf;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Self-checking bench for arith_op_sequencer with a behavioural arithmetic unit attached.
module tb_arith_op_sequencer;
    import arith_seq_pkg::*;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    logic [WIDTH-1:0] aluA, aluB, aluD, unitY;
    logic [1:0]       aluS;
    logic             aluCin, aluCout;

    arith_op_sequencer_if #(.WIDTH(WIDTH)) bus();

    arith_op_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .alu_a    (aluA),
        .alu_b    (aluB),
        .alu_s    (aluS),
        .alu_cin  (aluCin),
        .alu_d    (aluD),
        .alu_cout (aluCout)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Stand-in for the gate-level unit: B mux plus a plain adder.
    always_comb begin
        unitY = aluB;
        case (aluS)
            2'b00:   unitY = aluB;
            2'b01:   unitY = ~aluB;
            2'b10:   unitY = 4'h0;
            default: unitY = 4'hF;
        endcase
    end
    assign {aluCout, aluD} = {1'b0, aluA} + {1'b0, unitY} + {4'b0, aluCin};

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at 1 ms, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
    function automatic void refModel(input int a, input int b, input int s, input int cin,
                                     output int d, output int cout, output int zero,
                                     output int ovf);
        int y, sum, sa, sy, ssum;
        y    = (s == 0) ? b : (s == 1) ? (15 - b) : (s == 2) ? 0 : 15;
        sum  = a + y + cin;
        d    = sum % 16;
        cout = (sum >= 16) ? 1 : 0;
        zero = (d == 0) ? 1 : 0;
        sa   = (a >= 8) ? a - 16 : a;
        sy   = (y >= 8) ? y - 16 : y;
        ssum = sa + sy + cin;
        ovf  = (ssum > 7 || ssum < -8) ? 1 : 0;
    endfunction

    // Offer one request, wait for acceptance, then count cycles until the response appears.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                                 input logic cin, output int latency);
        int waited;
        @(negedge clk);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_s     = s;
        bus.req_cin   = cin;
        bus.req_valid = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            latency = -1;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        latency = 0;
        while (!bus.rsp_valid && latency < 50) begin
            @(negedge clk);
            latency++;
        end
        if (!bus.rsp_valid) latency = -1;
    endtask

    // Take the pending response with a single-cycle ready pulse.
    task automatic completeResponse();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_req_ready: got %b expected 0", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
        end
        checks++;
        if ({aluA, aluB, aluS, aluCin} !== 11'd0) begin
            fails++; $display("[TB] FAIL reset_alu: got %h expected 0", {aluA, aluB, aluS, aluCin});
        end
        checks++;
        if ({bus.rsp_d, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf} !== 7'd0) begin
            fails++; $display("[TB] FAIL reset_rsp: got %h expected 0",
                              {bus.rsp_d, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL release_req_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic [1:0] s;
        logic       cin;
        logic [3:0] d;
        logic       cout, zero, ovf;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[6];
        int   lat;
        vecs[0] = '{4'd3,  4'd2, SEL_B,    1'b0, 4'd5,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd5,  4'd5, SEL_NOTB, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{4'd7,  4'd1, SEL_B,    1'b0, 4'd8,  1'b0, 1'b0, 1'b1};
        vecs[3] = '{4'd8,  4'd1, SEL_NOTB, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1};
        vecs[4] = '{4'd15, 4'd9, SEL_ZERO, 1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
        vecs[5] = '{4'd0,  4'd6, SEL_ONES, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].cin, lat);
            checks++;
            if (lat !== SETTLE) begin
                fails++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, SETTLE);
            end
            checks++;
            if (bus.rsp_d !== vecs[i].d || bus.rsp_cout !== vecs[i].cout) begin
                fails++; $display("[TB] FAIL directed%0d_sum: got d=%0d cout=%b expected d=%0d cout=%b",
                                  i, bus.rsp_d, bus.rsp_cout, vecs[i].d, vecs[i].cout);
            end
            checks++;
            if (bus.rsp_zero !== vecs[i].zero || bus.rsp_ovf !== vecs[i].ovf) begin
                fails++; $display("[TB] FAIL directed%0d_flags: got zero=%b ovf=%b expected zero=%b ovf=%b",
                                  i, bus.rsp_zero, bus.rsp_ovf, vecs[i].zero, vecs[i].ovf);
            end
            completeResponse();
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                fails++; $display("[TB] FAIL directed%0d_handshake: got valid=%b ready=%b expected valid=0 ready=1",
                                  i, bus.rsp_valid, bus.req_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        logic [1:0] s;
        logic       cin;
        int         lat, d, cout, zero, ovf;
        for (int i = 0; i < 20; i++) begin
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            s   = 2'($urandom_range(0, 3));
            cin = 1'($urandom_range(0, 1));
            refModel(int'(a), int'(b), int'(s), int'(cin), d, cout, zero, ovf);
            applyStimulus(a, b, s, cin, lat);
            checks++;
            if (lat !== SETTLE) begin
                fails++; $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, lat, SETTLE);
            end
            checks++;
            if ({aluA, aluB, aluS, aluCin} !== {a, b, s, cin}) begin
                fails++; $display("[TB] FAIL random%0d_alu_inputs: got %h expected %h",
                                  i, {aluA, aluB, aluS, aluCin}, {a, b, s, cin});
            end
            checks++;
            if (int'(bus.rsp_d) != d || int'(bus.rsp_cout) != cout ||
                int'(bus.rsp_zero) != zero || int'(bus.rsp_ovf) != ovf) begin
                fails++; $display("[TB] FAIL random%0d_result: got d=%0d c=%0d z=%0d v=%0d expected d=%0d c=%0d z=%0d v=%0d",
                                  i, bus.rsp_d, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf, d, cout, zero, ovf);
            end
            completeResponse();
        end
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [6:0] snapRsp;
        logic [10:0] snapAlu;
        applyStimulus(4'd9, 4'd6, SEL_B, 1'b0, lat);
        snapRsp = {bus.rsp_d, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf};
        snapAlu = {aluA, aluB, aluS, aluCin};
        checks++;
        if (lat !== SETTLE || snapRsp !== {4'd15, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("[TB] FAIL bp_initial: got lat=%0d rsp=%h expected lat=%0d rsp=%h",
                              lat, snapRsp, SETTLE, {4'd15, 3'b000});
        end
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_a     = 4'($urandom_range(0, 15));
            bus.req_b     = 4'($urandom_range(0, 15));
            bus.req_s     = 2'($urandom_range(0, 3));
            bus.req_cin   = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if ({bus.rsp_d, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf} !== snapRsp || bus.rsp_valid !== 1'b1) begin
                fails++; $display("[TB] FAIL bp%0d_rsp_hold: got valid=%b rsp=%h expected valid=1 rsp=%h",
                                  i, bus.rsp_valid, {bus.rsp_d, bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf}, snapRsp);
            end
            checks++;
            if ({aluA, aluB, aluS, aluCin} !== snapAlu || bus.req_ready !== 1'b0) begin
                fails++; $display("[TB] FAIL bp%0d_alu_hold: got alu=%h ready=%b expected alu=%h ready=0",
                                  i, {aluA, aluB, aluS, aluCin}, bus.req_ready, snapAlu);
            end
        end
        bus.req_valid = 1'b1;
        bus.req_a     = 4'd1;
        bus.req_b     = 4'd1;
        bus.req_s     = SEL_ONES;
        bus.req_cin   = 1'b1;
        completeResponse();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1",
                              bus.rsp_valid, bus.req_ready);
        end
        checks++;
        if ({aluA, aluB, aluS, aluCin} !== snapAlu) begin
            fails++; $display("[TB] FAIL bp_ignored_req: got alu=%h expected %h",
                              {aluA, aluB, aluS, aluCin}, snapAlu);
        end
    endtask

    task automatic test_back_to_back();
        int  rises[$];
        bit  prev;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_a     = 4'd2;
        bus.req_b     = 4'd3;
        bus.req_s     = SEL_B;
        bus.req_cin   = 1'b0;
        bus.req_valid = 1'b1;
        prev = 1'b0;
        for (int cyc = 0; cyc < 60 && rises.size() < 3; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid && !prev) begin
                rises.push_back(cyc);
                checks++;
                if (bus.rsp_d !== 4'd5) begin
                    fails++; $display("[TB] FAIL b2b_sum: got %0d expected 5", bus.rsp_d);
                end
            end
            prev = bus.rsp_valid;
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (rises.size() != 3) begin
            fails++; $display("[TB] FAIL b2b_count: got %0d responses expected 3", rises.size());
        end else begin
            checks++;
            if (rises[1] - rises[0] != SETTLE + 2 || rises[2] - rises[1] != SETTLE + 2) begin
                fails++; $display("[TB] FAIL b2b_interval: got %0d,%0d expected %0d",
                                  rises[1] - rises[0], rises[2] - rises[1], SETTLE + 2);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        int lat, seen;
        @(negedge clk);
        bus.req_a     = 4'd4;
        bus.req_b     = 4'd4;
        bus.req_s     = SEL_B;
        bus.req_cin   = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if ({aluA, aluB} !== 8'h44) begin
            fails++; $display("[TB] FAIL mid_accept: got %h expected 44", {aluA, aluB});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({aluA, aluB, aluS, aluCin} !== 11'd0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL mid_reset: got alu=%h valid=%b ready=%b expected 0 0 0",
                              {aluA, aluB, aluS, aluCin}, bus.rsp_valid, bus.req_ready);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < SETTLE + 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || bus.req_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL mid_no_response: got %0d valid cycles ready=%b expected 0 ready=1",
                              seen, bus.req_ready);
        end
        applyStimulus(4'd6, 4'd1, SEL_NOTB, 1'b1, lat);
        checks++;
        if (lat !== SETTLE || bus.rsp_d !== 4'd5 || bus.rsp_cout !== 1'b1) begin
            fails++; $display("[TB] FAIL mid_recover: got lat=%0d d=%0d c=%b expected lat=%0d d=5 c=1",
                              lat, bus.rsp_d, bus.rsp_cout, SETTLE);
        end
        completeResponse();
    endtask

    // Run each scenario in order, then report.
    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_s     = '0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
